pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch, call/return and a circular return-address stack.
// Priority each edge: clear > stall > branch (optional push) > return (pop or miss) > sequential step.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_le,
  input  logic             i_br_taken,
  input  logic [WIDTH-1:0] i_br_target,
  input  logic             i_call,
  input  logic             i_ret,
  output logic [WIDTH-1:0] o_pc_out,
  output logic [WIDTH-1:0] o_pc_plus,
  output logic             o_ras_empty,
  output logic             o_ras_full,
  output logic             o_ret_miss
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_pc;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ret_miss;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  logic [WIDTH-1:0] w_pc_plus;
  logic [WIDTH-1:0] w_pc_next;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_push;
  logic             w_pop;
  logic             w_miss;
  logic             w_empty;
  logic             w_full;

  // r_ptr marks the next free slot; the top entry sits one below it (mod depth).
  assign w_pc_plus = r_pc + WIDTH'(STEP);
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_miss    = 1'b0;
    if (i_le) begin
      if (i_br_taken) begin
        w_pc_next = i_br_target;
        w_push    = i_call;
      end else if (i_ret) begin
        if (!w_empty) begin
          w_pc_next = r_ras[w_top_idx];
          w_pop     = 1'b1;
        end else begin
          w_pc_next = w_pc_plus;
          w_miss    = 1'b1;
        end
      end else begin
        w_pc_next = w_pc_plus;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_pc       <= RESET_VAL;
      r_ptr      <= '0;
      r_count    <= '0;
      r_ret_miss <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_ret_miss <= w_miss;
      if (w_push) begin
        r_ptr   <= r_ptr + PTR_W'(1);
        r_count <= w_full ? r_count : r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_ptr   <= w_top_idx;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // NOTE: stack storage is deliberately not reset; entries are only read once the count marks them valid.
  always_ff @(posedge i_clk) begin
    if (!i_clr && w_push) begin
      r_ras[r_ptr] <= w_pc_plus;
    end
  end

  assign o_pc_out    = r_pc;
  assign o_pc_plus   = w_pc_plus;
  assign o_ras_empty = w_empty;
  assign o_ras_full  = w_full;
  assign o_ret_miss  = r_ret_miss;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues hand-computed post-edge outputs,
// the monitor pops and compares one entry after every rising edge.
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        miss;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        le = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic        ras_empty;
  logic        ras_full;
  logic        ret_miss;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_VAL(32'h0), .RAS_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_clr(clr), .i_le(le), .i_br_taken(br), .i_br_target(tgt),
    .i_call(call), .i_ret(ret), .o_pc_out(pc_out), .o_pc_plus(pc_plus),
    .o_ras_empty(ras_empty), .o_ras_full(ras_full), .o_ret_miss(ret_miss)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
  endtask

  // One clock of stimulus plus the outputs expected right after the following rising edge.
  task automatic step(input string name, input logic c_clr, input logic c_le, input logic c_br,
                      input logic [31:0] c_tgt, input logic c_call, input logic c_ret,
                      input logic [31:0] e_pc, input logic e_empty, input logic e_full,
                      input logic e_miss);
    exp_t e;
    @(negedge clk);
    clr = c_clr; le = c_le; br = c_br; tgt = c_tgt; call = c_call; ret = c_ret;
    e.pc = e_pc; e.empty = e_empty; e.full = e_full; e.miss = e_miss; e.name = name;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] plus_req;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        plus_req = e.pc + 32'd4;
        check({e.name, ".pc"},      pc_out,          e.pc);
        check({e.name, ".pc_plus"}, pc_plus,         plus_req);
        check({e.name, ".empty"},   32'(ras_empty),  32'(e.empty));
        check({e.name, ".full"},    32'(ras_full),   32'(e.full));
        check({e.name, ".miss"},    32'(ret_miss),   32'(e.miss));
      end
    end
  end

  initial begin : driver
    //    name        clr le br target        call ret  pc            E  F  M
    step("reset",     1, 1, 1, 32'h0000_0700, 1, 1, 32'h0000_0000, 1, 0, 0);
    step("seq1",      0, 1, 0, 32'h0,         0, 0, 32'h0000_0004, 1, 0, 0);
    step("seq2",      0, 1, 0, 32'h0,         0, 0, 32'h0000_0008, 1, 0, 0);
    step("seq3",      0, 1, 0, 32'h0,         0, 0, 32'h0000_000C, 1, 0, 0);
    step("seq4",      0, 1, 0, 32'h0,         0, 0, 32'h0000_0010, 1, 0, 0);
    step("call100",   0, 1, 1, 32'h0000_0100, 1, 0, 32'h0000_0100, 0, 0, 0);
    step("seq104",    0, 1, 0, 32'h0,         0, 0, 32'h0000_0104, 0, 0, 0);
    step("ret14",     0, 1, 0, 32'h0,         0, 1, 32'h0000_0014, 1, 0, 0);
    step("br0",       0, 1, 1, 32'h0000_0000, 0, 0, 32'h0000_0000, 1, 0, 0);
    // five nested calls into a four-deep stack: the oldest return (0x4) is overwritten
    step("nest1",     0, 1, 1, 32'h0000_0100, 1, 0, 32'h0000_0100, 0, 0, 0);
    step("nest2",     0, 1, 1, 32'h0000_0200, 1, 0, 32'h0000_0200, 0, 0, 0);
    step("nest3",     0, 1, 1, 32'h0000_0300, 1, 0, 32'h0000_0300, 0, 0, 0);
    step("nest4",     0, 1, 1, 32'h0000_0400, 1, 0, 32'h0000_0400, 0, 1, 0);
    step("nest5",     0, 1, 1, 32'h0000_0500, 1, 0, 32'h0000_0500, 0, 1, 0);
    step("stall1",    0, 0, 1, 32'h0000_0900, 1, 1, 32'h0000_0500, 0, 1, 0);
    step("stall2",    0, 0, 1, 32'h0000_0900, 1, 1, 32'h0000_0500, 0, 1, 0);
    step("unw1",      0, 1, 0, 32'h0,         0, 1, 32'h0000_0404, 0, 0, 0);
    step("unw2",      0, 1, 0, 32'h0,         0, 1, 32'h0000_0304, 0, 0, 0);
    step("unw3",      0, 1, 0, 32'h0,         0, 1, 32'h0000_0204, 0, 0, 0);
    step("unw4",      0, 1, 0, 32'h0,         0, 1, 32'h0000_0104, 1, 0, 0);
    step("retmiss",   0, 1, 0, 32'h0,         0, 1, 32'h0000_0108, 1, 0, 1);
    step("misspulse", 0, 1, 0, 32'h0,         0, 0, 32'h0000_010C, 1, 0, 0);
    // CALL without a taken branch must not push
    step("callnobr",  0, 1, 0, 32'h0000_0800, 1, 0, 32'h0000_0110, 1, 0, 0);
    step("retnopush", 0, 1, 0, 32'h0,         0, 1, 32'h0000_0114, 1, 0, 1);
    step("seq118",    0, 1, 0, 32'h0,         0, 0, 32'h0000_0118, 1, 0, 0);
    step("brtop",     0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
    step("wrap",      0, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 1, 0, 0);
    step("call200",   0, 1, 1, 32'h0000_0200, 1, 0, 32'h0000_0200, 0, 0, 0);
    step("brret",     0, 1, 1, 32'h0000_0300, 0, 1, 32'h0000_0300, 0, 0, 0);
    step("ret4",      0, 1, 0, 32'h0,         0, 1, 32'h0000_0004, 1, 0, 0);
    step("call600",   0, 1, 1, 32'h0000_0600, 1, 0, 32'h0000_0600, 0, 0, 0);
    step("clrcall",   1, 1, 1, 32'h0000_0700, 1, 0, 32'h0000_0000, 1, 0, 0);
    step("retafter",  0, 1, 0, 32'h0,         0, 1, 32'h0000_0004, 1, 0, 1);
    step("seq8",      0, 1, 0, 32'h0,         0, 0, 32'h0000_0008, 1, 0, 0);
    // a clear pulse that falls back low before the edge must be ignored
    @(negedge clk);
    clr = 1'b0; le = 1'b1; br = 1'b0; call = 1'b0; ret = 1'b0;
    begin
      exp_t e;
      e.pc = 32'h0000_000C; e.empty = 1'b1; e.full = 1'b0; e.miss = 1'b0; e.name = "clrglitch";
      sb_q.push_back(e);
    end
    #1 clr = 1'b1;
    #2 clr = 1'b0;
    step("clrstall",  1, 0, 0, 32'h0,         0, 0, 32'h0000_0000, 1, 0, 0);
    step("seqpost",   0, 1, 0, 32'h0,         0, 0, 32'h0000_0004, 1, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #5;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: actual=%0d pending required=0 pending", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
